// File: rtl/m_wb_arb_pkg.sv
// Shared widths, source-tag encoding and helpers for the writeback arbiter.
package m_wb_arb_pkg;
  localparam int AW   = 5;   // register-file address width
  localparam int XLEN = 32;  // datapath width
  localparam int NREG = 32;  // architectural registers (width of the pending mask)

  // Which source loaded the output register; only long-unit writes are
  // reported in the pending mask.
  typedef enum logic {
    TAG_PIPE = 1'b0,
    TAG_LONG = 1'b1
  } src_tag_e;

  // One-hot decode of a destination register.
  function automatic logic [NREG-1:0] onehot_rd(input logic [AW-1:0] rd);
    onehot_rd     = '0;
    onehot_rd[rd] = 1'b1;
  endfunction
endpackage

// File: rtl/m_wb_fifo.sv
// Small synchronous FIFO for long-unit results. Exposes per-entry valid/rd
// so the parent can build a pending-destination mask without reading data.
module m_wb_fifo
  import m_wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_push,
  input  logic [AW-1:0]               i_push_rd,
  input  logic [XLEN-1:0]             i_push_data,
  input  logic                        i_pop,
  output logic [AW-1:0]               o_head_rd,
  output logic [XLEN-1:0]             o_head_data,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic [DEPTH-1:0]            o_ent_valid,
  output logic [DEPTH-1:0][AW-1:0]    o_ent_rd
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][AW-1:0] r_rd;
  logic [XLEN-1:0]          r_data [DEPTH];
  logic [DEPTH-1:0]         r_vld;
  logic [PW-1:0]            r_wptr;
  logic [PW-1:0]            r_rptr;
  logic [PW:0]              r_count;

  // Payload storage: written on push only, no reset needed.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_rd[r_wptr]   <= i_push_rd;
      r_data[r_wptr] <= i_push_data;
    end
  end

  // Pointers, occupancy and per-entry valid bits; pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (i_pop) begin
        r_rptr        <= r_rptr + 1'b1;
        r_vld[r_rptr] <= 1'b0;
      end
      if (i_push) begin
        r_wptr        <= r_wptr + 1'b1;
        r_vld[r_wptr] <= 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_rd   = r_rd[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_count     = r_count;
  assign o_ent_valid = r_vld;
  assign o_ent_rd    = r_rd;
endmodule

// File: rtl/m_wb_arb.sv
// Writeback arbiter / WB pipeline register in front of the single RF write
// port. The pipeline always wins; long-unit results wait in a FIFO and the
// pipeline is stalled once the FIFO head has lost STARVE_MAX times in a row.
//
// Long-unit handshake: a result transfers on a posedge where w_l_valid and
// w_l_ready are both 1. w_l_ready depends only on registered occupancy, and
// once w_l_valid is raised the producer holds rd/data until the transfer.
module m_wb_arb
  import m_wb_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_p_valid,
  input  logic [AW-1:0]    w_p_rd,
  input  logic [XLEN-1:0]  w_p_data,
  input  logic             w_l_valid,
  input  logic [AW-1:0]    w_l_rd,
  input  logic [XLEN-1:0]  w_l_data,
  output logic             w_l_ready,
  output logic             w_stall,
  output logic [NREG-1:0]  w_pend_mask,
  output logic             w_we,
  output logic [AW-1:0]    w_wa,
  output logic [XLEN-1:0]  w_wd
);
  localparam int              PW       = $clog2(DEPTH);
  localparam int              SW       = $clog2(STARVE_MAX + 1);
  localparam logic [PW:0]     FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [SW-1:0]   SMAX     = SW'(STARVE_MAX);

  logic [AW-1:0]             w_head_rd;
  logic [XLEN-1:0]           w_head_data;
  logic [PW:0]               w_count;
  logic [DEPTH-1:0]          w_ent_valid;
  logic [DEPTH-1:0][AW-1:0]  w_ent_rd;
  logic                      w_fifo_empty;
  logic                      w_p_win;
  logic                      w_l_take;
  logic                      w_pop;
  logic                      w_bypass;
  logic                      w_push;

  logic                      r_we;
  logic [AW-1:0]             r_wa;
  logic [XLEN-1:0]           r_wd;
  src_tag_e                  r_tag;
  logic [SW-1:0]             r_starve;

  // rd=0 from either source is a non-write: the pipeline counts as idle and
  // a long result is accepted and dropped.
  assign w_fifo_empty = (w_count == '0);
  assign w_l_ready    = (w_count < FULL_CNT);
  assign w_p_win      = w_p_valid && (w_p_rd != '0);
  assign w_l_take     = w_l_valid && w_l_ready && (w_l_rd != '0);
  assign w_pop        = !w_p_win && !w_fifo_empty;
  assign w_bypass     = !w_p_win && w_fifo_empty && w_l_take;
  assign w_push       = w_l_take && !w_bypass;
  assign w_stall      = (r_starve == SMAX);

  m_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (w_clk),
    .i_rst       (w_rst),
    .i_push      (w_push),
    .i_push_rd   (w_l_rd),
    .i_push_data (w_l_data),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_ent_valid (w_ent_valid),
    .o_ent_rd    (w_ent_rd)
  );

  // Output register load: pipeline, then FIFO head, then long-unit bypass.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_we  <= 1'b0;
      r_wa  <= '0;
      r_wd  <= '0;
      r_tag <= TAG_PIPE;
    end else if (w_p_win) begin
      r_we  <= 1'b1;
      r_wa  <= w_p_rd;
      r_wd  <= w_p_data;
      r_tag <= TAG_PIPE;
    end else if (w_pop) begin
      r_we  <= 1'b1;
      r_wa  <= w_head_rd;
      r_wd  <= w_head_data;
      r_tag <= TAG_LONG;
    end else if (w_bypass) begin
      r_we  <= 1'b1;
      r_wa  <= w_l_rd;
      r_wd  <= w_l_data;
      r_tag <= TAG_LONG;
    end else begin
      r_we  <= 1'b0;
    end
  end

  // Starvation counter: counts consecutive cycles a waiting head loses to
  // the pipeline, saturating; any pop or an empty FIFO clears it.
  always_ff @(posedge w_clk) begin
    if (w_rst || w_fifo_empty || w_pop) begin
      r_starve <= '0;
    end else if (w_p_win && (r_starve != SMAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Pending-destination mask: buffered long results plus a long result
  // currently sitting in the output register.
  always_comb begin
    w_pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i]) w_pend_mask = w_pend_mask | onehot_rd(w_ent_rd[i]);
    end
    if (r_we && (r_tag == TAG_LONG)) w_pend_mask = w_pend_mask | onehot_rd(r_wa);
  end

  assign w_we = r_we;
  assign w_wa = r_wa;
  assign w_wd = r_wd;

  // The pipeline must not present a result while stalled.
  a_no_pvalid_in_stall: assert property (@(posedge w_clk) disable iff (w_rst)
    !(w_stall && w_p_valid))
    else $error("protocol violation: w_p_valid asserted while w_stall");
endmodule
